// File: rtl/reg_file_pkg.sv
// Shared definitions for the integer register file: default sizing, clear-engine
// states and the address qualification helper used by every port.
package reg_file_pkg;

    localparam int DEF_XLEN  = 64;
    localparam int DEF_NREGS = 32;

    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } clr_state_e;

    // x0 and addresses past the end of a non-power-of-two file are never real storage.
    function automatic logic addr_valid(input int unsigned addr, input int unsigned nregs);
        return (addr != 0) && (addr < nregs);
    endfunction

endpackage

// File: rtl/reg_file_clear_fsm.sv
// Sequential clear engine: walks registers 1..NREGS-1, zeroing one per clock edge.
module reg_file_clear_fsm
    import reg_file_pkg::*;
#(
    parameter  int NREGS = DEF_NREGS,
    localparam int AW    = $clog2(NREGS)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          i_clr_req,
    output logic          o_clr_active,
    output logic          o_clr_we,
    output logic [AW-1:0] o_clr_idx
);

    clr_state_e    r_state;
    logic [AW-1:0] r_idx;

    // x0 is never stored, so the walk starts at 1 and the last edge clears NREGS-1.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_idx   <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (i_clr_req) begin
                        r_state <= CLEAR;
                        r_idx   <= AW'(1);
                    end
                end
                CLEAR: begin
                    r_idx <= r_idx + AW'(1);
                    if (r_idx == AW'(NREGS - 1)) begin
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign o_clr_active = (r_state == CLEAR);
    assign o_clr_we     = (r_state == CLEAR);
    assign o_clr_idx    = r_idx;

endmodule

// File: rtl/reg_file_sb.sv
// Integer register file with per-register busy scoreboard, same-cycle write
// forwarding on both read ports and a sequential whole-file clear.
module reg_file_sb
    import reg_file_pkg::*;
#(
    parameter  int XLEN  = DEF_XLEN,
    parameter  int NREGS = DEF_NREGS,
    localparam int AW    = $clog2(NREGS)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [AW-1:0]   rs1_addr,
    input  logic [AW-1:0]   rs2_addr,
    output logic [XLEN-1:0] rs1_data,
    output logic [XLEN-1:0] rs2_data,
    output logic            rs1_busy,
    output logic            rs2_busy,
    input  logic            we,
    input  logic [AW-1:0]   wr_addr,
    input  logic [XLEN-1:0] wr_data,
    input  logic            iss_valid,
    input  logic [AW-1:0]   iss_rd,
    input  logic            clr_req,
    output logic            clr_active
);

    logic [XLEN-1:0]  r_rf [NREGS];
    logic [NREGS-1:0] r_busy;

    logic          w_clr_we;
    logic [AW-1:0] w_clr_idx;
    logic          w_wr_ok;
    logic          w_iss_ok;
    logic          w_rs1_ok;
    logic          w_rs2_ok;

    reg_file_clear_fsm #(
        .NREGS (NREGS)
    ) u_clear_fsm (
        .clk          (clk),
        .rst_n        (rst_n),
        .i_clr_req    (clr_req),
        .o_clr_active (clr_active),
        .o_clr_we     (w_clr_we),
        .o_clr_idx    (w_clr_idx)
    );

    assign w_wr_ok  = we && addr_valid(32'(wr_addr), NREGS);
    assign w_iss_ok = iss_valid && addr_valid(32'(iss_rd), NREGS);
    assign w_rs1_ok = addr_valid(32'(rs1_addr), NREGS);
    assign w_rs2_ok = addr_valid(32'(rs2_addr), NREGS);

    // Issue is applied after the write so a same-register write+issue leaves it busy.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREGS; i++) begin
                r_rf[i] <= '0;
            end
            r_busy <= '0;
        end else if (w_clr_we) begin
            r_rf[w_clr_idx]   <= '0;
            r_busy[w_clr_idx] <= 1'b0;
        end else begin
            if (w_wr_ok) begin
                r_rf[wr_addr]   <= wr_data;
                r_busy[wr_addr] <= 1'b0;
            end
            if (w_iss_ok) begin
                r_busy[iss_rd] <= 1'b1;
            end
        end
    end

    always_comb begin
        rs1_data = '0;
        rs1_busy = 1'b0;
        if (w_rs1_ok) begin
            if (clr_active) begin
                rs1_data = r_rf[rs1_addr];
                rs1_busy = 1'b1;
            end else if (we && (wr_addr == rs1_addr)) begin
                rs1_data = wr_data;
                rs1_busy = 1'b0;
            end else begin
                rs1_data = r_rf[rs1_addr];
                rs1_busy = r_busy[rs1_addr];
            end
        end
    end

    always_comb begin
        rs2_data = '0;
        rs2_busy = 1'b0;
        if (w_rs2_ok) begin
            if (clr_active) begin
                rs2_data = r_rf[rs2_addr];
                rs2_busy = 1'b1;
            end else if (we && (wr_addr == rs2_addr)) begin
                rs2_data = wr_data;
                rs2_busy = 1'b0;
            end else begin
                rs2_data = r_rf[rs2_addr];
                rs2_busy = r_busy[rs2_addr];
            end
        end
    end

endmodule

// File: tb/tb_reg_file_sb.sv
// Directed bench for reg_file_sb: a vector table for read/write/issue behaviour,
// then hand sequences for the clear engine, reset mid-clear and a 24x32 instance.
module tb_reg_file_sb;

    localparam logic [63:0] BEEF = 64'hDEAD_BEEF_0000_0001;

    logic        clk;
    logic        rst_n;
    logic [4:0]  rs1Addr, rs2Addr, wrAddr, issRd;
    logic [63:0] rs1Data, rs2Data, wrData;
    logic        rs1Busy, rs2Busy, we, issValid, clrReq, clrActive;

    logic [4:0]  bRs1Addr, bRs2Addr, bWrAddr, bIssRd;
    logic [31:0] bRs1Data, bRs2Data, bWrData;
    logic        bRs1Busy, bRs2Busy, bWe, bIssValid, bClrReq, bClrActive;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic        we;
        logic [4:0]  wrAddr;
        logic [63:0] wrData;
        logic        issValid;
        logic [4:0]  issRd;
        logic [4:0]  rs1Addr;
        logic [4:0]  rs2Addr;
        logic [63:0] expRs1;
        logic [63:0] expRs2;
        logic        expBusy1;
        logic        expBusy2;
    } vec_t;

    localparam int NVEC = 18;
    vec_t vecs [NVEC];

    reg_file_sb #(.XLEN(64), .NREGS(32)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .rs1_addr   (rs1Addr),
        .rs2_addr   (rs2Addr),
        .rs1_data   (rs1Data),
        .rs2_data   (rs2Data),
        .rs1_busy   (rs1Busy),
        .rs2_busy   (rs2Busy),
        .we         (we),
        .wr_addr    (wrAddr),
        .wr_data    (wrData),
        .iss_valid  (issValid),
        .iss_rd     (issRd),
        .clr_req    (clrReq),
        .clr_active (clrActive)
    );

    reg_file_sb #(.XLEN(32), .NREGS(24)) dut24 (
        .clk        (clk),
        .rst_n      (rst_n),
        .rs1_addr   (bRs1Addr),
        .rs2_addr   (bRs2Addr),
        .rs1_data   (bRs1Data),
        .rs2_data   (bRs2Data),
        .rs1_busy   (bRs1Busy),
        .rs2_busy   (bRs2Busy),
        .we         (bWe),
        .wr_addr    (bWrAddr),
        .wr_data    (bWrData),
        .iss_valid  (bIssValid),
        .iss_rd     (bIssRd),
        .clr_req    (bClrReq),
        .clr_active (bClrActive)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input vec_t v);
        we       = v.we;
        wrAddr   = v.wrAddr;
        wrData   = v.wrData;
        issValid = v.issValid;
        issRd    = v.issRd;
        rs1Addr  = v.rs1Addr;
        rs2Addr  = v.rs2Addr;
    endtask

    initial begin
        // we, wrAddr, wrData, iss, issRd, rs1, rs2, expRs1, expRs2, busy1, busy2
        vecs[0]  = '{1'b0, 5'd0, 64'h0,    1'b0, 5'd0, 5'd5, 5'd0, 64'h0,    64'h0,    1'b0, 1'b0};
        vecs[1]  = '{1'b1, 5'd5, BEEF,     1'b0, 5'd0, 5'd5, 5'd0, BEEF,     64'h0,    1'b0, 1'b0};
        vecs[2]  = '{1'b0, 5'd0, 64'h0,    1'b0, 5'd0, 5'd5, 5'd0, BEEF,     64'h0,    1'b0, 1'b0};
        vecs[3]  = '{1'b1, 5'd7, 64'h1234, 1'b0, 5'd0, 5'd7, 5'd5, 64'h1234, BEEF,     1'b0, 1'b0};
        vecs[4]  = '{1'b1, 5'd0, 64'hFFFF, 1'b0, 5'd0, 5'd0, 5'd7, 64'h0,    64'h1234, 1'b0, 1'b0};
        vecs[5]  = '{1'b0, 5'd0, 64'h0,    1'b0, 5'd0, 5'd0, 5'd7, 64'h0,    64'h1234, 1'b0, 1'b0};
        vecs[6]  = '{1'b0, 5'd0, 64'h0,    1'b1, 5'd3, 5'd3, 5'd5, 64'h0,    BEEF,     1'b0, 1'b0};
        vecs[7]  = '{1'b0, 5'd0, 64'h0,    1'b0, 5'd0, 5'd3, 5'd5, 64'h0,    BEEF,     1'b1, 1'b0};
        vecs[8]  = '{1'b1, 5'd3, 64'h9,    1'b0, 5'd0, 5'd3, 5'd5, 64'h9,    BEEF,     1'b0, 1'b0};
        vecs[9]  = '{1'b0, 5'd0, 64'h0,    1'b0, 5'd0, 5'd3, 5'd5, 64'h9,    BEEF,     1'b0, 1'b0};
        vecs[10] = '{1'b1, 5'd4, 64'h8,    1'b1, 5'd4, 5'd4, 5'd3, 64'h8,    64'h9,    1'b0, 1'b0};
        vecs[11] = '{1'b0, 5'd0, 64'h0,    1'b0, 5'd0, 5'd4, 5'd3, 64'h8,    64'h9,    1'b1, 1'b0};
        vecs[12] = '{1'b0, 5'd0, 64'h0,    1'b1, 5'd0, 5'd0, 5'd3, 64'h0,    64'h9,    1'b0, 1'b0};
        vecs[13] = '{1'b0, 5'd0, 64'h0,    1'b0, 5'd0, 5'd0, 5'd4, 64'h0,    64'h8,    1'b0, 1'b1};
        vecs[14] = '{1'b0, 5'd0, 64'h0,    1'b1, 5'd4, 5'd4, 5'd3, 64'h8,    64'h9,    1'b1, 1'b0};
        vecs[15] = '{1'b0, 5'd0, 64'h0,    1'b0, 5'd0, 5'd4, 5'd3, 64'h8,    64'h9,    1'b1, 1'b0};
        vecs[16] = '{1'b1, 5'd4, 64'hA,    1'b0, 5'd0, 5'd4, 5'd3, 64'hA,    64'h9,    1'b0, 1'b0};
        vecs[17] = '{1'b0, 5'd0, 64'h0,    1'b0, 5'd0, 5'd4, 5'd3, 64'hA,    64'h9,    1'b0, 1'b0};

        rst_n = 1'b0;
        {we, issValid, clrReq} = '0;
        {wrAddr, issRd, rs1Addr, rs2Addr} = '0;
        wrData = '0;
        {bWe, bIssValid, bClrReq} = '0;
        {bWrAddr, bIssRd, bRs1Addr, bRs2Addr} = '0;
        bWrData = '0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        #1;
        checkOutput("reset.clrActive", 64'(clrActive), 64'h0);

        for (int i = 0; i < NVEC; i++) begin
            applyStimulus(vecs[i]);
            #1;
            checkOutput($sformatf("v%0d.rs1Data", i), rs1Data, vecs[i].expRs1);
            checkOutput($sformatf("v%0d.rs2Data", i), rs2Data, vecs[i].expRs2);
            checkOutput($sformatf("v%0d.rs1Busy", i), 64'(rs1Busy), 64'(vecs[i].expBusy1));
            checkOutput($sformatf("v%0d.rs2Busy", i), 64'(rs2Busy), 64'(vecs[i].expBusy2));
            tick();
        end
        we = 1'b0;
        issValid = 1'b0;

        // Fill x1..x31 with their index and leave x2 busy before starting the clear.
        for (int r = 1; r < 32; r++) begin
            we = 1'b1;
            wrAddr = 5'(r);
            wrData = 64'(r);
            tick();
        end
        we = 1'b0;
        issValid = 1'b1;
        issRd = 5'd2;
        tick();
        issValid = 1'b0;
        rs1Addr = 5'd2;
        #1;
        checkOutput("preclear.x2Busy", 64'(rs1Busy), 64'h1);

        clrReq = 1'b1;
        tick();
        clrReq = 1'b0;
        for (int c = 0; c < 31; c++) begin
            if (c == 4) begin
                we = 1'b1;
                wrAddr = 5'd10;
                wrData = 64'hFF;
                rs1Addr = 5'd10;
                #1;
                checkOutput("clear.noForwardData", rs1Data, 64'd10);
                checkOutput("clear.forcedBusy", 64'(rs1Busy), 64'h1);
            end
            checkOutput($sformatf("clear.active%0d", c), 64'(clrActive), 64'h1);
            tick();
            we = 1'b0;
        end
        checkOutput("clear.doneInactive", 64'(clrActive), 64'h0);
        for (int r = 0; r < 32; r++) begin
            rs1Addr = 5'(r);
            #1;
            checkOutput($sformatf("clear.x%0dData", r), rs1Data, 64'h0);
            checkOutput($sformatf("clear.x%0dBusy", r), 64'(rs1Busy), 64'h0);
        end
        we = 1'b1;
        wrAddr = 5'd6;
        wrData = 64'd77;
        tick();
        we = 1'b0;
        rs1Addr = 5'd6;
        #1;
        checkOutput("postclear.writeAccepted", rs1Data, 64'd77);

        // Reset in the middle of a clear, before x20 has been reached.
        we = 1'b1;
        wrAddr = 5'd20;
        wrData = 64'd20;
        tick();
        we = 1'b0;
        clrReq = 1'b1;
        tick();
        clrReq = 1'b0;
        repeat (9) tick();
        rs1Addr = 5'd20;
        rs2Addr = 5'd6;
        #1;
        checkOutput("midclear.x20Data", rs1Data, 64'd20);
        checkOutput("midclear.active", 64'(clrActive), 64'h1);
        rst_n = 1'b0;
        #1;
        checkOutput("rstclear.x20Data", rs1Data, 64'h0);
        checkOutput("rstclear.x6Data", rs2Data, 64'h0);
        checkOutput("rstclear.active", 64'(clrActive), 64'h0);
        tick();
        rst_n = 1'b1;
        we = 1'b1;
        wrAddr = 5'd20;
        wrData = 64'd55;
        tick();
        we = 1'b0;
        #1;
        checkOutput("postrst.writeAccepted", rs1Data, 64'd55);
        checkOutput("postrst.inactive", 64'(clrActive), 64'h0);

        // 24-entry, 32-bit instance: out-of-range addresses are inert.
        bWe = 1'b1;
        bWrAddr = 5'd30;
        bWrData = 32'h5555_5555;
        bRs1Addr = 5'd30;
        #1;
        checkOutput("n24.oorForward", 64'(bRs1Data), 64'h0);
        tick();
        bWrAddr = 5'd23;
        bWrData = 32'hA5A5_A5A5;
        tick();
        bWe = 1'b0;
        bIssValid = 1'b1;
        bIssRd = 5'd30;
        tick();
        bIssRd = 5'd23;
        tick();
        bIssValid = 1'b0;
        bRs1Addr = 5'd30;
        bRs2Addr = 5'd23;
        #1;
        checkOutput("n24.oorData", 64'(bRs1Data), 64'h0);
        checkOutput("n24.oorBusy", 64'(bRs1Busy), 64'h0);
        checkOutput("n24.x23Data", 64'(bRs2Data), 64'hA5A5_A5A5);
        checkOutput("n24.x23Busy", 64'(bRs2Busy), 64'h1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/reg_file_sb.md
# reg_file_sb

Parametrised integer register file with per-register scoreboard and a sequential clear engine, sitting between decode/issue and writeback in the core datapath. Two combinational read ports with same-cycle write forwarding. One write port. x0 is hardwired to zero. Busy bits let issue stall on registers with outstanding long-latency writes, and a clear request zeroes the whole file one register per cycle.

## Interface
Parameters:
- XLEN, 64, data width in bits.
- NREGS, 32, number of architectural registers (≥2).
- AW, $clog2(NREGS), address width; localparam, not overridable.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- rs1_addr  in  AW  read port 1 address.
- rs2_addr  in  AW  read port 2 address.
- rs1_data  out  XLEN  read port 1 data (combinational).
- rs2_data  out  XLEN  read port 2 data (combinational).
- rs1_busy  out  1  register on port 1 has a pending write.
- rs2_busy  out  1  register on port 2 has a pending write.
- we  in  1  write enable.
- wr_addr  in  AW  write address.
- wr_data  in  XLEN  write data.
- iss_valid  in  1  issue of an instruction that will write iss_rd.
- iss_rd  in  AW  destination register being issued.
- clr_req  in  1  request a full sequential clear.
- clr_active  out  1  clear engine running.

## Operation
- Reset (rst_n low, any time): all registers = 0, all busy bits = 0, clear FSM = IDLE.
  - Outputs during and after reset until the first write: rs*_data = 0, rs*_busy = 0, clr_active = 0.
  - Reset mid-clear aborts the clear.
- Read:
  - rsN_data = RF[rsN_addr].
  - Forwarding: if we && wr_addr == rsN_addr && wr_addr != 0 && !clr_active, then rsN_data = wr_data and rsN_busy = 0 in the same cycle.
- x0:
  - Reads return 0 and busy = 0.
  - Writes and issues to x0 are ignored.
- Out of range: when NREGS is not a power of two, addresses ≥ NREGS read 0 with busy = 0; writes and issues to them are ignored.
- Write: on a clock edge with we && !clr_active, RF[wr_addr] ← wr_data and busy[wr_addr] ← 0.
- Issue: on a clock edge with iss_valid && !clr_active, busy[iss_rd] ← 1.
  - Issue to an already-busy register keeps it busy.
  - The next write clears it (no per-register counting).
- Simultaneous write and issue to the same register: the data is written and busy ends at 1 (issue wins).
- Clear FSM, states IDLE and CLEAR:
  - IDLE → CLEAR when clr_req is sampled high. Index loads 1. Any we/iss in that same cycle is still performed.
  - In CLEAR, each edge does RF[idx] ← 0, busy[idx] ← 0, idx ← idx+1.
  - CLEAR → IDLE on the edge that clears NREGS-1.
  - In CLEAR: we and iss_valid are ignored, clr_req is ignored, rs*_busy are forced to 1 for every nonzero address, and rs*_data return current array contents with no forwarding.

## Timing
- Read latency 0 (combinational from addresses, we, wr_addr and wr_data).
- Write and issue take effect after one edge.
- clr_req sampled high at edge k:
  - clr_active = 1 from after edge k through edge k+NREGS-1.
  - Registers 1..NREGS-1 are zeroed at edges k+1..k+NREGS-1.
  - clr_active = 0 after edge k+NREGS-1; new writes are accepted at edge k+NREGS.
- rst_n is asserted asynchronously and must be deasserted synchronously to clk (an external synchroniser is responsible).

## Structure
- Package reg_file_pkg:
  - default XLEN and NREGS;
  - clear-state enum (IDLE, CLEAR);
  - function addr_valid(addr) (nonzero and < NREGS).
- Sub-module reg_file_clear_fsm:
  - holds state and the AW-bit index;
  - outputs clr_active, clr_we and clr_idx.
- Top level holds the array, busy vector, read muxes and forwarding logic.

## Test plan
- Reset, then write x5 = 64'hDEAD_BEEF_0000_0001 → after the edge, reading rs1_addr = 5 returns that value; reading rs2_addr = 0 returns 0.
- we = 1, wr_addr = 7, wr_data = 64'h1234, rs1_addr = 7 in the same cycle → rs1_data = 64'h1234 before the edge; write to x0 with 64'hFFFF → x0 still reads 0.
- Issue rd = 3 → rs1_busy = 1 at addr 3 next cycle; write x3 = 9 → rs1_busy = 0 combinationally in that cycle and stays 0; simultaneous issue and write to x4 = 8 → x4 = 8 and busy = 1.
- Fill x1..x31 with their index, pulse clr_req at edge k → clr_active high for 31 cycles; a write to x10 at k+5 is ignored; all registers = 0 and all busy = 0 at k+32.
- Assert rst_n low mid-clear (at k+10) with x20 = 20 → immediately all reads = 0, clr_active = 0; after release, writes are accepted on the next edge.
- NREGS = 24, XLEN = 32: write addr 30 → ignored, reads 0; write x23 = 32'hA5A5_A5A5 → readback matches.
